// File: rtl/dmem_portb_arbiter.sv
// Round-robin arbiter sharing data-memory port B between the AXI bridge (rq0)
// and the matrix-multiply operand loader/storer (rq1). Define DMEM_ARB_FIXED_PRI_EN for fixed rq1 priority.
module dmem_portb_arbiter #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 256,
    parameter int NUM_COL  = 4,
    localparam int ADDR_W  = $clog2(SIZE) + 2
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic                rq0_valid,
    output logic                rq0_ready,
    input  logic [ADDR_W-1:0]   rq0_addr,
    input  logic [WIDTH-1:0]    rq0_wdata,
    input  logic [NUM_COL-1:0]  rq0_be,
    output logic                rq0_rsp_valid,
    input  logic                rq0_rsp_ready,
    output logic [WIDTH-1:0]    rq0_rdata,

    input  logic                rq1_valid,
    output logic                rq1_ready,
    input  logic [ADDR_W-1:0]   rq1_addr,
    input  logic [WIDTH-1:0]    rq1_wdata,
    input  logic [NUM_COL-1:0]  rq1_be,
    output logic                rq1_rsp_valid,
    input  logic                rq1_rsp_ready,
    output logic [WIDTH-1:0]    rq1_rdata,

    output logic [ADDR_W-1:0]   mem_byte_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    output logic [NUM_COL-1:0]  mem_byte_wr_en,
    input  logic [WIDTH-1:0]    mem_rdata,

    output logic                busy,
    output logic                grant_id
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

    state_t               r_state;
    logic                 r_grant;
    logic [ADDR_W-1:0]    r_addr;
    logic [WIDTH-1:0]     r_wdata;
    logic [NUM_COL-1:0]   r_wr_en;
    logic                 r_rsp_valid0;
    logic                 r_rsp_valid1;
    logic                 r_captured;
    logic [WIDTH-1:0]     r_rdata0;
    logic [WIDTH-1:0]     r_rdata1;
`ifndef DMEM_ARB_FIXED_PRI_EN
    logic                 r_rr_last;
`endif

    logic                 w_sel;
    logic                 w_grant_go;
    logic [ADDR_W-1:0]    w_addr;
    logic [WIDTH-1:0]     w_wdata;
    logic [NUM_COL-1:0]   w_be;
    logic                 w_rsp_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_sel = 1'b0;
        if (rq0_valid && rq1_valid) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
            w_sel = 1'b1;
`else
            w_sel = ~r_rr_last;
`endif
        end else begin
            w_sel = rq1_valid;
        end
    end

    assign w_grant_go  = (r_state == S_IDLE) && (rq0_valid || rq1_valid);
    assign rq0_ready   = w_grant_go && !w_sel;
    assign rq1_ready   = w_grant_go &&  w_sel;
    assign w_addr      = w_sel ? rq1_addr  : rq0_addr;
    assign w_wdata     = w_sel ? rq1_wdata : rq0_wdata;
    assign w_be        = w_sel ? rq1_be    : rq0_be;
    assign w_rsp_ready = r_grant ? rq1_rsp_ready : rq0_rsp_ready;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wr_en      <= '0;
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_captured   <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
`ifndef DMEM_ARB_FIXED_PRI_EN
            r_rr_last    <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_go) begin
                        r_addr    <= w_addr & ~ADDR_W'(3);
                        r_wdata   <= w_wdata;
                        r_wr_en   <= w_be;
                        r_grant   <= w_sel;
`ifndef DMEM_ARB_FIXED_PRI_EN
                        r_rr_last <= w_sel;
`endif
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_wr_en    <= '0;
                    r_captured <= 1'b0;
                    if (r_grant) r_rsp_valid1 <= 1'b1;
                    else         r_rsp_valid0 <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    // Memory keeps re-reading the word during RESP; after a write
                    // that is the new value, so the first-cycle read is frozen.
                    if (!r_captured) begin
                        r_captured <= 1'b1;
                        if (r_grant) r_rdata1 <= mem_rdata;
                        else         r_rdata0 <= mem_rdata;
                    end
                    if (w_rsp_ready) begin
                        r_rsp_valid0 <= 1'b0;
                        r_rsp_valid1 <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rq0_rdata      = (r_state == S_RESP && !r_grant && !r_captured) ? mem_rdata : r_rdata0;
    assign rq1_rdata      = (r_state == S_RESP &&  r_grant && !r_captured) ? mem_rdata : r_rdata1;
    assign rq0_rsp_valid  = r_rsp_valid0;
    assign rq1_rsp_valid  = r_rsp_valid1;
    assign mem_byte_addr  = r_addr;
    assign mem_wdata      = r_wdata;
    assign mem_byte_wr_en = r_wr_en;
    assign busy           = (r_state != S_IDLE);
    assign grant_id       = r_grant;

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Directed testbench for dmem_portb_arbiter with a byte-lane, read-before-write
// memory model on port B.
module tb_dmem_portb_arbiter;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              rq0_valid = 0, rq1_valid = 0;
    logic              rq0_ready, rq1_ready;
    logic [ADDR_W-1:0] rq0_addr = '0, rq1_addr = '0;
    logic [WIDTH-1:0]  rq0_wdata = '0, rq1_wdata = '0;
    logic [3:0]        rq0_be = '0, rq1_be = '0;
    logic              rq0_rsp_valid, rq1_rsp_valid;
    logic              rq0_rsp_ready = 1, rq1_rsp_ready = 1;
    logic [WIDTH-1:0]  rq0_rdata, rq1_rdata;
    logic [ADDR_W-1:0] mem_byte_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [3:0]        mem_byte_wr_en;
    logic [WIDTH-1:0]  mem_rdata = '0;
    logic              busy, grant_id;

    logic [WIDTH-1:0]  mem_array [0:255];

    int n_checks = 0;
    int n_errors = 0;

    dmem_portb_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_addr(rq0_addr),
        .rq0_wdata(rq0_wdata), .rq0_be(rq0_be), .rq0_rsp_valid(rq0_rsp_valid),
        .rq0_rsp_ready(rq0_rsp_ready), .rq0_rdata(rq0_rdata),
        .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_addr(rq1_addr),
        .rq1_wdata(rq1_wdata), .rq1_be(rq1_be), .rq1_rsp_valid(rq1_rsp_valid),
        .rq1_rsp_ready(rq1_rsp_ready), .rq1_rdata(rq1_rdata),
        .mem_byte_addr(mem_byte_addr), .mem_wdata(mem_wdata),
        .mem_byte_wr_en(mem_byte_wr_en), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Synchronous port-B memory: old contents on data_out, byte-lane writes.
    always @(posedge clk) begin
        mem_rdata <= mem_array[mem_byte_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (mem_byte_wr_en[b]) mem_array[mem_byte_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One isolated access with rsp_ready high, checked cycle by cycle.
    task automatic do_access(input logic req, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input logic [31:0] exp_rdata, input string tag);
        logic [ADDR_W-1:0] exp_addr;
        exp_addr = addr & ~ADDR_W'(3);
        @(negedge clk);
        rq0_rsp_ready = 1'b1;
        rq1_rsp_ready = 1'b1;
        if (req) begin rq1_valid = 1; rq1_addr = addr; rq1_wdata = wdata; rq1_be = be; end
        else     begin rq0_valid = 1; rq0_addr = addr; rq0_wdata = wdata; rq0_be = be; end
        #1;
        check({tag, "_ready"}, {31'd0, req ? rq1_ready : rq0_ready}, 32'd1);
        check({tag, "_other_ready"}, {31'd0, req ? rq0_ready : rq1_ready}, 32'd0);
        @(negedge clk);
        rq0_valid = 0;
        rq1_valid = 0;
        #1;
        check({tag, "_issue_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_issue_wr_en"}, {28'd0, mem_byte_wr_en}, {28'd0, be});
        check({tag, "_issue_addr"}, {22'd0, mem_byte_addr}, {22'd0, exp_addr});
        check({tag, "_grant_id"}, {31'd0, grant_id}, {31'd0, req});
        @(negedge clk);
        #1;
        check({tag, "_rsp_valid"}, {31'd0, req ? rq1_rsp_valid : rq0_rsp_valid}, 32'd1);
        check({tag, "_other_rsp_valid"}, {31'd0, req ? rq0_rsp_valid : rq1_rsp_valid}, 32'd0);
        check({tag, "_rdata"}, req ? rq1_rdata : rq0_rdata, exp_rdata);
        check({tag, "_resp_wr_en"}, {28'd0, mem_byte_wr_en}, 32'd0);
        @(negedge clk);
        #1;
        check({tag, "_done_rsp_valid"}, {31'd0, req ? rq1_rsp_valid : rq0_rsp_valid}, 32'd0);
        check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    endtask

    int    g_id   [4];
    int    g_cyc  [4];
    int    n_g;
    logic [31:0] held;

    initial begin
        for (int i = 0; i < 256; i++) mem_array[i] = 32'h0;
        mem_array[5] = 32'hDEADBEEF;
        mem_array[3] = 32'h11223344;
        mem_array[8] = 32'hCAFEF00D;

        // Reset state
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wr_en", {28'd0, mem_byte_wr_en}, 32'd0);
        check("rst_addr", {22'd0, mem_byte_addr}, 32'd0);
        check("rst_rsp_valid", {30'd0, rq1_rsp_valid, rq0_rsp_valid}, 32'd0);
        check("rst_grant_id", {31'd0, grant_id}, 32'd0);
        check("rst_rdata0", rq0_rdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single read, byte write with read-before-write, readback with low address bits set
        do_access(1'b0, 10'h014, 32'h0, 4'b0000, 32'hDEADBEEF, "rd");
        do_access(1'b1, 10'h00C, 32'hAABBCCDD, 4'b0101, 32'h11223344, "wr");
        check("wr_mem_word", mem_array[3], 32'h11BB33DD);
        do_access(1'b1, 10'h00F, 32'h0, 4'b0000, 32'h11BB33DD, "rdback");

        // Contention: both valid from reset
        @(negedge clk);
        reset_n = 1'b0;
        rq0_valid = 1; rq0_addr = 10'h014; rq0_be = 0; rq0_rsp_ready = 1;
        rq1_valid = 1; rq1_addr = 10'h00C; rq1_be = 0; rq1_rsp_ready = 1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n_g = 0;
        for (int c = 0; c < 20 && n_g < 4; c++) begin
            #1;
            if (rq0_ready || rq1_ready) begin
                check("cont_single_ready", {31'd0, rq0_ready && rq1_ready}, 32'd0);
                g_id[n_g]  = rq1_ready ? 1 : 0;
                g_cyc[n_g] = c;
                n_g++;
            end
            @(negedge clk);
        end
        rq0_valid = 0;
        rq1_valid = 0;
        check("cont_grant_count", n_g, 4);
        for (int i = 0; i < n_g; i++) begin
`ifdef DMEM_ARB_FIXED_PRI_EN
            check($sformatf("cont_id%0d", i), g_id[i], 1);
`else
            check($sformatf("cont_id%0d", i), g_id[i], i % 2);
`endif
            if (i > 0) check($sformatf("cont_gap%0d", i), g_cyc[i] - g_cyc[i-1], 3);
        end

        // Backpressure on rq0 response while rq1 waits
        apply_reset();
        @(negedge clk);
        rq0_valid = 1; rq0_addr = 10'h014; rq0_be = 0; rq0_rsp_ready = 0;
        rq1_rsp_ready = 1;
        #1;
        check("bp_ready0", {31'd0, rq0_ready}, 32'd1);
        @(negedge clk);
        rq0_valid = 0;
        rq1_valid = 1; rq1_addr = 10'h00C; rq1_be = 0;
        #1;
        check("bp_issue_ready1", {31'd0, rq1_ready}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp_rsp_valid0_%0d", k), {31'd0, rq0_rsp_valid}, 32'd1);
            check($sformatf("bp_rdata0_%0d", k), rq0_rdata, 32'hDEADBEEF);
            check($sformatf("bp_ready1_%0d", k), {31'd0, rq1_ready}, 32'd0);
        end
        @(negedge clk);
        rq0_rsp_ready = 1;
        #1;
        check("bp_release_ready1", {31'd0, rq1_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("bp_grant1", {31'd0, rq1_ready}, 32'd1);
        check("bp_rsp_valid0_clr", {31'd0, rq0_rsp_valid}, 32'd0);
        @(negedge clk);
        rq1_valid = 0;
        @(negedge clk);
        #1;
        check("bp_rsp_valid1", {31'd0, rq1_rsp_valid}, 32'd1);
        check("bp_rdata1", rq1_rdata, 32'h11BB33DD);
        check("bp_rdata0_hold", rq0_rdata, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        check("bp_idle", {31'd0, busy}, 32'd0);

        // Reset asserted during ISSUE of a full-word write
        apply_reset();
        @(negedge clk);
        rq0_valid = 1; rq0_addr = 10'h020; rq0_wdata = 32'h0; rq0_be = 4'hF;
        #1;
        check("rw_ready0", {31'd0, rq0_ready}, 32'd1);
        @(negedge clk);
        rq0_valid = 0;
        #1;
        check("rw_issue_wr_en", {28'd0, mem_byte_wr_en}, 32'hF);
        #2;
        reset_n = 1'b0;
        #1;
        check("rw_wr_en_dropped", {28'd0, mem_byte_wr_en}, 32'd0);
        check("rw_busy", {31'd0, busy}, 32'd0);
        check("rw_rsp_valid", {30'd0, rq1_rsp_valid, rq0_rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        held = mem_array[8];
        check("rw_mem_unchanged", held, 32'hCAFEF00D);
        do_access(1'b0, 10'h020, 32'h0, 4'b0000, 32'hCAFEF00D, "rw_readback");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_portb_arbiter.md
Name: dmem_portb_arbiter

Overview:
- Shares data memory port B (byte address, write data, byte write enables, 1-cycle synchronous read) between two requesters.
  - Requester 0: the AXI bridge.
  - Requester 1: the matrix-multiply operand loader/storer.
- Round-robin arbitration with valid/ready request and response handshakes.
- Sequences each single-word access through a 3-state FSM; returns read data, or pre-write contents on writes, to the granted requester.

Parameters:
- WIDTH, 32, bits per memory word.
- SIZE, 256, memory depth in words.
- NUM_COL, 4, byte lanes per word (COL_WIDTH = WIDTH/NUM_COL).
- ADDR_W, $clog2(SIZE)+2, byte-address width (localparam).

Ports:
- clk  in  1  single clock; also drives memory port B clock.
- reset_n  in  1  asynchronous active-low reset.
- rq0_valid  in  1  requester 0 access request.
- rq0_ready  out  1  request accepted this cycle.
- rq0_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- rq0_wdata  in  WIDTH  write data.
- rq0_be  in  NUM_COL  byte write enables; all-zero means read.
- rq0_rsp_valid  out  1  response available.
- rq0_rsp_ready  in  1  requester 0 takes response.
- rq0_rdata  out  WIDTH  response data.
- rq1_valid, rq1_ready, rq1_addr, rq1_wdata, rq1_be, rq1_rsp_valid, rq1_rsp_ready, rq1_rdata: identical set for requester 1.
- mem_byte_addr  out  ADDR_W  to memory byte_addr_B.
- mem_wdata  out  WIDTH  to memory data_in_B.
- mem_byte_wr_en  out  NUM_COL  to memory byte_wr_en_B.
- mem_rdata  in  WIDTH  from memory data_out_B.
- busy  out  1  FSM not IDLE.
- grant_id  out  1  requester currently owning the port.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all outputs 0; rr_last=1, so requester 0 wins the first tie.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the one not equal to rr_last.
  - Grant cycle: rqN_ready=1 combinationally for exactly one requester; latch addr, wdata and be into mem_* registers; grant_id=N; rr_last=N; go to ISSUE.
  - No valid: stay in IDLE, mem_byte_wr_en=0.
- ISSUE (1 cycle):
  - mem_* outputs stable and registered; memory samples them at the closing edge.
  - mem_byte_wr_en = latched be.
  - Go to RESP.
- RESP:
  - Entering RESP: mem_byte_wr_en forced 0; rqN_rdata captured from mem_rdata; rqN_rsp_valid=1.
  - Hold rqN_rsp_valid and rqN_rdata stable until rqN_rsp_ready=1, then clear rsp_valid and go to IDLE.
- Latency: request accept to rsp_valid = 2 cycles. Peak throughput: one access per 3 cycles with rsp_ready held high.
- Writes return the word contents before the write (read-before-write); the write itself is complete when rsp_valid rises.
- No new grant while busy: rqN_ready=0 in ISSUE and RESP. Requests must hold valid and payload until ready.
- Non-granted requester's rsp_valid stays 0; its rdata holds its last value.
- Address: mem_byte_addr = rqN_addr with [1:0] forced 0.
- Starvation bound: a requester asserting valid is granted within 2 arbitration rounds (≤6 cycles plus the other side's response wait).
- Reset during ISSUE before the edge: write suppressed (mem_byte_wr_en=0 immediately).
- Reset during RESP: response dropped; the requester must reissue.
- Requester dropping valid without ready: legal; no grant is recorded.

Optional Feature:
- DMEM_ARB_FIXED_PRI_EN defined:
  - Requester 1 always wins ties; rr_last unused.
  - A new request from requester 1 in IDLE preempts requester 0 every time.
- Undefined: round-robin as above.

Test Plan:
- Single read: preload word 5=0xDEADBEEF; rq0 read addr 0x14, be=0 → rq0_ready in cycle 0, mem_byte_wr_en=0 throughout, rq0_rsp_valid in cycle 2 with rdata=0xDEADBEEF.
- Byte write: word 3=0x11223344; rq1 write addr 0x0C, wdata 0xAABBCCDD, be=0b0101 → mem_byte_wr_en=0b0101 only in ISSUE; rsp rdata=0x11223344; a subsequent read returns 0x11BB33DD.
- Contention: rq0 and rq1 valid continuously from reset with rsp_ready=1 → grant order 0,1,0,1; each grant 3 cycles apart; no two consecutive grants to the same requester.
- Backpressure: rq0 read, rq0_rsp_ready held 0 for 4 cycles with rq1 valid → rq0_rsp_valid and rdata stable, rq1_ready=0; rq1 granted the cycle after rq0_rsp_ready=1 is sampled in RESP.
- Reset mid-write: assert reset_n=0 during ISSUE of a write with be=0xF → mem_byte_wr_en drops before the edge; memory word unchanged; busy=0, all rsp_valid=0 after reset.
- With DMEM_ARB_FIXED_PRI_EN: both valid continuously → all grants to rq1 until rq1_valid drops; then rq0 granted.
